misr_sig_checker: RTL and testbench

Multiple-input signature register (MISR) response compactor and checker, the receiving end of the team's LFSR pattern generator. It accepts configuration commands and compacts a fixed number of response vectors into an 8-bit signature, using the same tap convention as the generator. It then compares the final signature against a programmed golden value and reports pass or fail. It sits between the circuit-under-test outputs and the test controller.

---
 rtl/misr_sig_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_misr_sig_checker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/misr_sig_checker.sv
// -----------------------------------------------------------------------------
// misr_sig_checker
//
// Multiple-input signature register (MISR) response compactor and checker.
// Commands configure the tap vector, seed the signature, program the golden
// value and start a compaction run of a programmed number of vectors. When
// the run ends, the final signature is compared against the golden value and
// the pass/fail result is held until the next real command or an abort.
//
// Optional feature macro: MISR_MASK_EN
//   defined   -> din_mask port exists; masked bits (1) contribute 0.
//   undefined -> no din_mask port; din is compacted as is.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command present
//   cmd_ready  command accepted when cmd_valid && cmd_ready
//   cmd_op     3-bit opcode (NOP/CONFIG/INIT/GOLD/START, 101..111 = NOP)
//   cmd_arg    command argument
//   din_valid  response vector present
//   din_ready  vector accepted when din_valid && din_ready
//   din        response vector
//   din_mask   X-mask, 1 = ignore bit (MISR_MASK_EN only)
//   abort      synchronous abort back to IDLE
//   sig        current signature register
//   busy       high in COMPACT and COMPARE
//   done       comparison complete
//   pass       signature matched golden (valid while done = 1)
// -----------------------------------------------------------------------------
module misr_sig_checker #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic [WIDTH-1:0] din,
`ifdef MISR_MASK_EN
    input  logic [WIDTH-1:0] din_mask,
`endif
    input  logic             abort,
    output logic [WIDTH-1:0] sig,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    localparam logic [2:0] OP_CONFIG = 3'b001;
    localparam logic [2:0] OP_INIT   = 3'b010;
    localparam logic [2:0] OP_GOLD   = 3'b011;
    localparam logic [2:0] OP_START  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPACT = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sig_q, sig_d;
    logic [WIDTH-2:0]   tap_q, tap_d;
    logic [WIDTH-1:0]   golden_q, golden_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               cmd_fire;
    logic               din_fire;
    logic               real_cmd;
    logic [WIDTH-1:0]   d_eff;
    logic [WIDTH-1:0]   sig_comp;
    logic               fb;

    // ---------------------------------------------------------------- inputs
`ifdef MISR_MASK_EN
    assign d_eff = din & ~din_mask;
`else
    assign d_eff = din;
`endif

    assign cmd_fire = cmd_valid && cmd_ready;
    assign din_fire = din_valid && din_ready;
    // Opcodes 101..111 behave exactly like NOP, so only 001..100 count as
    // commands that leave the DONE state.
    assign real_cmd = (cmd_op >= OP_CONFIG) && (cmd_op <= OP_START);

    // ------------------------------------------------------ compaction step
    // Galois-style MISR: the MSB feeds back into bit 0 and into every bit
    // whose tap is set, and each bit also absorbs its response bit.
    assign fb          = sig_q[WIDTH-1];
    assign sig_comp[0] = fb ^ d_eff[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_misr
            assign sig_comp[gi] = sig_q[gi-1] ^ (tap_q[gi-1] & fb) ^ d_eff[gi];
        end
    endgenerate

    // -------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_fire && cmd_op == OP_START) begin
                        state_d = (cmd_arg == '0) ? ST_COMPARE : ST_COMPACT;
                    end
                end
                ST_COMPACT: begin
                    if (din_fire && count_q == WIDTH'(1)) begin
                        state_d = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (cmd_fire && real_cmd) begin
                        if (cmd_op == OP_START) begin
                            state_d = (cmd_arg == '0) ? ST_COMPARE : ST_COMPACT;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    // Readies decode from the state register; abort overrides them so
    // nothing is consumed in the abort cycle.
    always_comb begin
        cmd_ready = 1'b0;
        din_ready = 1'b0;
        if (!abort) begin
            cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
            din_ready = (state_q == ST_COMPACT);
        end
    end

    // -------------------------------------------------------------- datapath
    always_comb begin
        sig_d    = sig_q;
        tap_d    = tap_q;
        golden_d = golden_q;
        count_d  = count_q;
        done_d   = done_q;
        pass_d   = pass_q;
        if (abort) begin
            done_d = 1'b0;
            pass_d = 1'b0;
        end else begin
            if (cmd_fire) begin
                case (cmd_op)
                    OP_CONFIG: tap_d    = cmd_arg[WIDTH-2:0];
                    OP_INIT:   sig_d    = cmd_arg;
                    OP_GOLD:   golden_d = cmd_arg;
                    OP_START:  count_d  = cmd_arg;
                    default:   ;
                endcase
                if (real_cmd) begin
                    done_d = 1'b0;
                    pass_d = 1'b0;
                end
            end
            if (din_fire) begin
                sig_d   = sig_comp;
                count_d = count_q - WIDTH'(1);
            end
            if (state_q == ST_COMPARE) begin
                done_d = 1'b1;
                pass_d = (sig_q == golden_q);
            end
        end
        busy_d = (state_d == ST_COMPACT) || (state_d == ST_COMPARE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_q    <= '0;
            tap_q    <= '0;
            golden_q <= '0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            sig_q    <= sig_d;
            tap_q    <= tap_d;
            golden_q <= golden_d;
            count_q  <= count_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign sig  = sig_q;
    assign busy = busy_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// -----------------------------------------------------------------------------
// tb_misr_sig_checker
//
// Directed-vector bench for misr_sig_checker. Inputs change at the falling
// edge (or 1 time unit after the rising edge); outputs are sampled at the
// falling edge. Each scenario task does its own comparisons against
// hand-computed signatures.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_misr_sig_checker;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_arg;
    logic             din_valid;
    logic             din_ready;
    logic [WIDTH-1:0] din;
`ifdef MISR_MASK_EN
    logic [WIDTH-1:0] din_mask;
`endif
    logic             abort;
    logic [WIDTH-1:0] sig;
    logic             busy;
    logic             done;
    logic             pass;

    int n_cmp = 0;
    int n_err = 0;

    misr_sig_checker #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .din       (din),
`ifdef MISR_MASK_EN
        .din_mask  (din_mask),
`endif
        .abort     (abort),
        .sig       (sig),
        .busy      (busy),
        .done      (done),
        .pass      (pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive one command for one cycle (only used where cmd_ready is high).
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 8'h00;
    endtask

    task automatic send_vec(input logic [7:0] d);
        @(negedge clk);
        din_valid = 1'b1;
        din       = d;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din       = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({sig, busy, done, pass, cmd_ready, din_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got sig=%h busy=%b done=%b pass=%b cmd_ready=%b din_ready=%b, want 00 0 0 0 1 0",
                     sig, busy, done, pass, cmd_ready, din_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset: sig=%h cmd_ready=%b", sig, cmd_ready);
    endtask

    // tap 0, seed 0, vector 0x5A -> sig 0x5A, matches golden.
    task automatic test_basic_pass();
        send_cmd(3'b001, 8'h00);
        send_cmd(3'b010, 8'h00);
        send_cmd(3'b011, 8'h5A);
        send_cmd(3'b100, 8'h01);
        @(negedge clk);
        n_cmp++;
        if (din_ready !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_din_ready: got din_ready=%b busy=%b, want 1 1", din_ready, busy);
        end
        din_valid = 1'b1;
        din       = 8'h5A;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sig !== 8'h5A || done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_compare_cycle: got sig=%h done=%b busy=%b, want 5a 0 1", sig, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL basic_result: got done=%b pass=%b busy=%b, want 1 1 0", done, pass, busy);
        end
        $display("test_basic_pass: sig=%h done=%b pass=%b", sig, done, pass);
    endtask

    // tap 0x25, seed 0x80, vector 0 -> sig = {tap,1} = 0x4B, golden 0 -> fail.
    task automatic test_tap_fail();
        send_cmd(3'b001, 8'h25);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || pass !== 1'b0) begin
            n_err++;
            $display("FAIL tap_done_clear: got done=%b pass=%b, want 0 0", done, pass);
        end
        send_cmd(3'b010, 8'h80);
        send_cmd(3'b011, 8'h00);
        send_cmd(3'b100, 8'h01);
        send_vec(8'h00);
        @(negedge clk);
        n_cmp++;
        if (sig !== 8'h4B) begin
            n_err++;
            $display("FAIL tap_sig: got %h, want 4b", sig);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            n_err++;
            $display("FAIL tap_result: got done=%b pass=%b, want 1 0", done, pass);
        end
        $display("test_tap_fail: sig=%h done=%b pass=%b", sig, done, pass);
    endtask

    // START 0 goes straight to COMPARE; NOP-class commands keep done.
    task automatic test_zero_count();
        send_cmd(3'b010, 8'h3C);
        send_cmd(3'b011, 8'h3C);
        send_cmd(3'b100, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (din_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL zero_compare: got din_ready=%b busy=%b done=%b, want 0 1 0", din_ready, busy, done);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || sig !== 8'h3C) begin
            n_err++;
            $display("FAIL zero_result: got done=%b pass=%b sig=%h, want 1 1 3c", done, pass, sig);
        end
        send_cmd(3'b101, 8'hAA);
        send_cmd(3'b000, 8'h00);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL zero_nop_hold: got done=%b pass=%b cmd_ready=%b, want 1 1 1", done, pass, cmd_ready);
        end
        $display("test_zero_count: done=%b pass=%b", done, pass);
    endtask

    // Abort blocks the offered vector; rst mid-run clears everything.
    task automatic test_abort_reset();
        send_cmd(3'b001, 8'h00);
        send_cmd(3'b010, 8'h01);
        send_cmd(3'b100, 8'h03);
        send_vec(8'h10);                 // rotl(01) ^ 10 = 12
        @(negedge clk);
        din_valid = 1'b1;
        din       = 8'hFF;
        abort     = 1'b1;
        #1;
        n_cmp++;
        if (din_ready !== 1'b0 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_readies: got din_ready=%b cmd_ready=%b, want 0 0", din_ready, cmd_ready);
        end
        @(posedge clk);
        #1;
        abort     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sig !== 8'h12 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || din_ready !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle: got sig=%h busy=%b done=%b cmd_ready=%b din_ready=%b, want 12 0 0 1 0",
                     sig, busy, done, cmd_ready, din_ready);
        end
        send_cmd(3'b100, 8'h02);
        send_vec(8'h33);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sig, busy, done, pass, cmd_ready, din_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL async_reset: got sig=%h busy=%b done=%b pass=%b cmd_ready=%b din_ready=%b, want 00 0 0 0 1 0",
                     sig, busy, done, pass, cmd_ready, din_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_abort_reset: sig=%h busy=%b", sig, busy);
    endtask

    // Vectors 81,00,00,00 with gaps, tap 0, seed 0 -> 81,03,06,0C.
    // A GOLD command offered mid-run must be refused.
    task automatic test_back_to_back();
        logic [7:0] vecs [4];
        vecs[0] = 8'h81; vecs[1] = 8'h00; vecs[2] = 8'h00; vecs[3] = 8'h00;
        send_cmd(3'b001, 8'h00);
        send_cmd(3'b010, 8'h00);
        send_cmd(3'b011, 8'h0C);
        send_cmd(3'b100, 8'h04);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            din_valid = (i % 2 == 0);
            din       = vecs[i/2];
            cmd_valid = (i == 1);
            cmd_op    = 3'b011;
            cmd_arg   = 8'hEE;
            if (i == 1 || i == 2) begin
                n_cmp++;
                if (sig !== 8'h81) begin
                    n_err++;
                    $display("FAIL gap_hold_%0d: got sig=%h, want 81", i, sig);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (cmd_ready !== 1'b0 || din_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL compact_cmd_ready: got cmd_ready=%b din_ready=%b, want 0 1", cmd_ready, din_ready);
                end
            end
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            cmd_valid = 1'b0;
            cmd_op    = 3'b000;
        end
        @(negedge clk);
        n_cmp++;
        if (sig !== 8'h0C || done !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_compare: got sig=%h done=%b busy=%b, want 0c 0 1", sig, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_result: got done=%b pass=%b busy=%b, want 1 1 0 (golden must stay 0c)", done, pass, busy);
        end
        $display("test_back_to_back: sig=%h done=%b pass=%b", sig, done, pass);
    endtask

    // Masked build: all-ones vector fully masked -> sig stays 0.
    // Unmasked build: all-ones vector with seed 0, tap 0 -> sig = FF.
    task automatic test_mask();
        logic [7:0] want;
        send_cmd(3'b001, 8'h00);
        send_cmd(3'b010, 8'h00);
        send_cmd(3'b100, 8'h01);
`ifdef MISR_MASK_EN
        din_mask = 8'hFF;
        want     = 8'h00;
`else
        want     = 8'hFF;
`endif
        send_vec(8'hFF);
        @(negedge clk);
        n_cmp++;
        if (sig !== want) begin
            n_err++;
            $display("FAIL mask_sig: got %h, want %h", sig, want);
        end
`ifdef MISR_MASK_EN
        din_mask = 8'h00;
`endif
        @(negedge clk);
        $display("test_mask: sig=%h done=%b", sig, done);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_arg   = 8'h00;
        din_valid = 1'b0;
        din       = 8'h00;
`ifdef MISR_MASK_EN
        din_mask  = 8'h00;
`endif
        abort     = 1'b0;

        test_reset();
        test_basic_pass();
        test_tap_fail();
        test_zero_count();
        test_abort_reset();
        test_back_to_back();
        test_mask();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
